// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller
// Central stall/flush sequencer for the 5-stage RV32 pipeline. It merges these events into
// one set of per-stage register enables and bubble-insert flushes:
//   - load-use hazards
//   - multi-cycle MDU waits
//   - data-memory wait states
//   - branch redirects
// It also keeps a consecutive-stall watchdog and a running count of stalled cycles.
module pipeline_stall_controller #(
  parameter int unsigned MAX_STALL = 15,
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned PERF_W    = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              id_ex_mem_read,
  input  logic [4:0]        id_ex_rd,
  input  logic [4:0]        if_id_rs1,
  input  logic [4:0]        if_id_rs2,
  input  logic              mdu_start,
  input  logic              mdu_done,
  input  logic              dmem_req,
  input  logic              dmem_ready,
  input  logic              branch_taken,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              id_ex_write,
  output logic              ex_mem_write,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              ex_mem_flush,
  output logic              stall_timeout,
  output logic [PERF_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MDU_WAIT = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             done_seen;
  logic             done_seen_nxt;
  logic [CNT_W-1:0] watchdog;

  logic load_use;
  logic mem_stall;
  logic run_rules;
  logic mdu_release;

  // Hazard terms; x0 is never a real dependency.
  assign load_use  = id_ex_mem_read && (id_ex_rd != 5'd0) &&
                     ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));
  assign mem_stall = dmem_req && !dmem_ready;

  // The normal RUN priority chain applies either in RUN without a memory stall, or on the
  // cycle a pending memory access completes; both paths share a single decode below.
  assign run_rules   = ((state == RUN) && !mem_stall) || ((state == MEM_WAIT) && dmem_ready);
  assign mdu_release = mdu_done || done_seen;

  // State register and latched MDU completion
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RUN;
      done_seen <= 1'b0;
    end else begin
      state     <= state_nxt;
      done_seen <= done_seen_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt     = state;
    done_seen_nxt = done_seen;
    unique case (state)
      RUN: begin
        if (mem_stall) begin
          state_nxt = MEM_WAIT;
        end else if (mdu_start) begin
          state_nxt = MDU_WAIT;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_nxt = mdu_start ? MDU_WAIT : RUN;
        end
      end
      MDU_WAIT: begin
        if (mem_stall) begin
          done_seen_nxt = done_seen || mdu_done;
        end else if (mdu_release) begin
          done_seen_nxt = 1'b0;
          state_nxt     = RUN;
        end
      end
      default: begin
        state_nxt     = RUN;
        done_seen_nxt = 1'b0;
      end
    endcase
  end

  // Per-stage enables and flushes from state and live hazards
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    ex_mem_write = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    if (run_rules) begin
      if (mdu_start) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_write  = 1'b0;
        ex_mem_flush = 1'b1;
      end else if (branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
      end
    end else if ((state == MDU_WAIT) && !mem_stall) begin
      if (!mdu_release) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_write  = 1'b0;
        ex_mem_flush = 1'b1;
      end
    end else begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
    end
  end

  // Consecutive-stall watchdog with sticky timeout flag
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      watchdog      <= '0;
      stall_timeout <= 1'b0;
    end else begin
      if (watchdog == CNT_W'(MAX_STALL)) begin
        stall_timeout <= 1'b1;
      end
      if (state == RUN) begin
        watchdog <= '0;
      end else if (watchdog != '1) begin
        watchdog <= watchdog + CNT_W'(1);
      end
    end
  end

  // Stalled-cycle performance counter, wraps naturally
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= '0;
    end else if (!pc_write) begin
      stall_cycles <= stall_cycles + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Testbench for pipeline_stall_controller: directed scenarios plus random traffic, checked by
// a scoreboard fed from a behavioural model of the stall/flush rules.
module tb_pipeline_stall_controller;

  localparam int unsigned MAX_STALL = 15;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned PERF_W    = 16;
  localparam int unsigned WD_SAT    = (1 << CNT_W) - 1;

  logic              clock;
  logic              reset_n;
  logic              id_ex_mem_read;
  logic [4:0]        id_ex_rd;
  logic [4:0]        if_id_rs1;
  logic [4:0]        if_id_rs2;
  logic              mdu_start;
  logic              mdu_done;
  logic              dmem_req;
  logic              dmem_ready;
  logic              branch_taken;
  logic              pc_write;
  logic              if_id_write;
  logic              id_ex_write;
  logic              ex_mem_write;
  logic              if_id_flush;
  logic              id_ex_flush;
  logic              ex_mem_flush;
  logic              stall_timeout;
  logic [PERF_W-1:0] stall_cycles;

  pipeline_stall_controller #(
    .MAX_STALL(MAX_STALL),
    .CNT_W    (CNT_W),
    .PERF_W   (PERF_W)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .id_ex_mem_read(id_ex_mem_read),
    .id_ex_rd      (id_ex_rd),
    .if_id_rs1     (if_id_rs1),
    .if_id_rs2     (if_id_rs2),
    .mdu_start     (mdu_start),
    .mdu_done      (mdu_done),
    .dmem_req      (dmem_req),
    .dmem_ready    (dmem_ready),
    .branch_taken  (branch_taken),
    .pc_write      (pc_write),
    .if_id_write   (if_id_write),
    .id_ex_write   (id_ex_write),
    .ex_mem_write  (ex_mem_write),
    .if_id_flush   (if_id_flush),
    .id_ex_flush   (id_ex_flush),
    .ex_mem_flush  (ex_mem_flush),
    .stall_timeout (stall_timeout),
    .stall_cycles  (stall_cycles)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic       mr;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       start;
    logic       done;
    logic       req;
    logic       rdy;
    logic       br;
  } stim_t;

  // wr = {pc, if_id, id_ex, ex_mem}; fl = {if_id, id_ex, ex_mem}
  typedef struct packed {
    logic [3:0]        wr;
    logic [2:0]        fl;
    logic [PERF_W-1:0] cyc;
    logic              to;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Behavioural model: what the pipeline is waiting on, plus the statistics.
  bit          waiting_mem;
  bit          waiting_mdu;
  bit          mdu_finished;
  int unsigned streak;
  bit          m_timeout;
  int unsigned m_stalled;

  function automatic void model_reset();
    waiting_mem  = 0;
    waiting_mdu  = 0;
    mdu_finished = 0;
    streak       = 0;
    m_timeout    = 0;
    m_stalled    = 0;
  endfunction

  function automatic void model_eval(input stim_t s, output logic [3:0] wr,
                                     output logic [2:0] fl, output bit n_mem,
                                     output bit n_mdu, output bit n_fin);
    bit lu;
    bit ms;
    lu    = s.mr && (s.rd != 0) && ((s.rd == s.rs1) || (s.rd == s.rs2));
    ms    = s.req && !s.rdy;
    wr    = 4'b1111;
    fl    = 3'b000;
    n_mem = 0;
    n_mdu = 0;
    n_fin = mdu_finished;
    if (waiting_mdu) begin
      if (ms) begin
        wr    = 4'b0000;
        n_mdu = 1;
        n_fin = mdu_finished || s.done;
      end else if (s.done || mdu_finished) begin
        n_fin = 0;
      end else begin
        wr    = 4'b0001;
        fl    = 3'b001;
        n_mdu = 1;
      end
    end else if ((waiting_mem && !s.rdy) || (!waiting_mem && ms)) begin
      wr    = 4'b0000;
      n_mem = 1;
    end else if (s.start) begin
      wr    = 4'b0001;
      fl    = 3'b001;
      n_mdu = 1;
    end else if (s.br) begin
      fl = 3'b110;
    end else if (lu) begin
      wr = 4'b0011;
      fl = 3'b010;
    end
  endfunction

  task automatic apply(input stim_t s);
    id_ex_mem_read = s.mr;
    id_ex_rd       = s.rd;
    if_id_rs1      = s.rs1;
    if_id_rs2      = s.rs2;
    mdu_start      = s.start;
    mdu_done       = s.done;
    dmem_req       = s.req;
    dmem_ready     = s.rdy;
    branch_taken   = s.br;
  endtask

  // One clock of stimulus: push the expected response, then advance the model past the edge.
  task automatic drive(input stim_t s);
    exp_t       e;
    logic [3:0] wr;
    logic [2:0] fl;
    bit         n_mem;
    bit         n_mdu;
    bit         n_fin;
    assert (!(s.start && s.br)) else $error("FAIL illegal_stim mdu_start with branch_taken");
    apply(s);
    model_eval(s, wr, fl, n_mem, n_mdu, n_fin);
    e.wr  = wr;
    e.fl  = fl;
    e.cyc = PERF_W'(m_stalled);
    e.to  = m_timeout;
    q.push_back(e);
    @(posedge clock);
    if (!wr[3]) m_stalled = (m_stalled + 1) % (1 << PERF_W);
    if (streak >= MAX_STALL) m_timeout = 1;
    if (!waiting_mem && !waiting_mdu) streak = 0;
    else if (streak < WD_SAT) streak = streak + 1;
    waiting_mem  = n_mem;
    waiting_mdu  = n_mdu;
    mdu_finished = n_fin;
    #1;
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  // Reset asserted for two edges; outputs are checked while reset is still low.
  task automatic do_reset();
    exp_t e;
    reset_n = 1'b0;
    apply(idle());
    model_reset();
    e.wr  = 4'b1111;
    e.fl  = 3'b000;
    e.cyc = '0;
    e.to  = 1'b0;
    q.push_back(e);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs are valid every cycle; compare mid-cycle against the scoreboard head.
  exp_t m;
  initial begin
    forever begin
      @(negedge clock);
      if (q.size() > 0) begin
        m = q.pop_front();
        check("writes", 32'({pc_write, if_id_write, id_ex_write, ex_mem_write}), 32'(m.wr));
        check("flushes", 32'({if_id_flush, id_ex_flush, ex_mem_flush}), 32'(m.fl));
        check("stall_cycles", 32'(stall_cycles), 32'(m.cyc));
        check("stall_timeout", 32'(stall_timeout), 32'(m.to));
      end
    end
  end

  stim_t s;

  initial begin
    reset_n = 1'b0;
    apply(idle());
    do_reset();
    repeat (2) drive(idle());

    // Load-use on rs1, then on rs2
    s = idle(); s.mr = 1; s.rd = 5'd5; s.rs1 = 5'd5; drive(s);
    drive(idle());
    s = idle(); s.mr = 1; s.rd = 5'd9; s.rs2 = 5'd9; s.rs1 = 5'd3; drive(s);
    // x0 load never stalls
    s = idle(); s.mr = 1; s.rd = 5'd0; s.rs1 = 5'd0; drive(s);
    // Branch beats load-use
    s = idle(); s.mr = 1; s.rd = 5'd7; s.rs1 = 5'd7; s.br = 1; drive(s);
    drive(idle());

    // MDU op completing four cycles after issue
    s = idle(); s.start = 1; drive(s);
    repeat (3) drive(idle());
    s = idle(); s.done = 1; drive(s);
    repeat (2) drive(idle());

    // Memory wait overlapping MDU completion
    s = idle(); s.start = 1; drive(s);
    drive(idle());
    s = idle(); s.req = 1; drive(s);
    s.done = 1; drive(s);
    s.done = 0; drive(s);
    s = idle(); s.req = 1; s.rdy = 1; drive(s);
    repeat (2) drive(idle());

    // Watchdog: long memory wait, then release; timeout stays set
    s = idle(); s.req = 1;
    repeat (20) drive(s);
    s.rdy = 1; drive(s);
    repeat (3) drive(idle());

    // Async reset in the middle of an MDU wait; the late completion is ignored
    s = idle(); s.start = 1; drive(s);
    repeat (2) drive(idle());
    do_reset();
    s = idle(); s.done = 1; drive(s);
    repeat (2) drive(idle());

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      s       = idle();
      s.mr    = ($urandom_range(0, 2) == 0);
      s.rd    = 5'($urandom_range(0, 3));
      s.rs1   = 5'($urandom_range(0, 3));
      s.rs2   = 5'($urandom_range(0, 3));
      s.start = ($urandom_range(0, 9) == 0);
      s.done  = ($urandom_range(0, 5) == 0);
      s.req   = ($urandom_range(0, 2) == 0);
      s.rdy   = ($urandom_range(0, 1) == 0);
      s.br    = !s.start && ($urandom_range(0, 7) == 0);
      drive(s);
    end

    repeat (2) @(negedge clock);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
